// File: rtl/cnt_run_ctrl_if.sv
// Control/status bundle between a run sequencer (master) and cnt_run_ctrl (slave).
interface cnt_run_ctrl_if #(
  parameter int WIDTH = 4,
  parameter int REP_W = 4
);
  logic             start;
  logic             pause;
  logic             stop;
  logic [WIDTH-1:0] cfg_limit;
  logic [REP_W-1:0] cfg_reps;
  logic             cfg_auto;
  logic [WIDTH-1:0] cnt;
  logic [REP_W-1:0] rep_cnt;
  logic             busy;
  logic             paused;
  logic             tc_pulse;
  logic             done;

  modport master (
    output start, pause, stop, cfg_limit, cfg_reps, cfg_auto,
    input  cnt, rep_cnt, busy, paused, tc_pulse, done
  );

  modport slave (
    input  start, pause, stop, cfg_limit, cfg_reps, cfg_auto,
    output cnt, rep_cnt, busy, paused, tc_pulse, done
  );
endinterface

// File: rtl/cnt_run_ctrl.sv
// Run controller for a WIDTH-bit up-counter: start/pause/stop sequencing over
// cfg_reps periods of cfg_limit+1 cycles, with optional automatic re-arm.
module cnt_run_ctrl #(
  parameter int WIDTH = 4,
  parameter int REP_W = 4
) (
  input  logic          sys_clk,
  input  logic          sys_rst_n,
  cnt_run_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_RUN,
    S_HOLD,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, lim_q;
  logic [REP_W-1:0] rep_q, reps_q;
  logic             auto_q, tc_q;
  logic             at_limit, last_rep;

  assign at_limit = (cnt_q == lim_q);
  assign last_rep = (REP_W'(rep_q + 1'b1) == reps_q);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of process ordering.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state_q <= S_IDLE;
    else            state_q <= state_d;
  end

  // NOTE: state_d gets a default first so no path through the case infers a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (bus.start) state_d = S_ARM;
      S_ARM:  state_d = bus.stop ? S_IDLE : S_RUN;
      S_RUN: begin
        if (bus.stop)                state_d = S_IDLE;
        else if (bus.pause)          state_d = S_HOLD;
        else if (at_limit && last_rep) state_d = S_DONE;
      end
      S_HOLD: begin
        if (bus.stop)        state_d = S_IDLE;
        else if (!bus.pause) state_d = S_RUN;
      end
      S_DONE: state_d = auto_q ? S_ARM : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Counter, repetition count, tick and the configuration snapshot taken at start.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_q  <= '0;
      rep_q  <= '0;
      tc_q   <= 1'b0;
      lim_q  <= '0;
      reps_q <= '0;
      auto_q <= 1'b0;
    end else begin
      tc_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          cnt_q <= '0;
          if (bus.start) begin
            lim_q  <= bus.cfg_limit;
            reps_q <= (bus.cfg_reps == '0) ? REP_W'(1) : bus.cfg_reps;
            auto_q <= bus.cfg_auto;
          end
        end
        S_ARM: begin
          cnt_q <= '0;
          rep_q <= '0;
        end
        S_RUN: begin
          if (bus.stop) begin
            cnt_q <= '0;
          end else if (!bus.pause) begin
            if (at_limit) begin
              cnt_q <= '0;
              tc_q  <= 1'b1;
              rep_q <= REP_W'(rep_q + 1'b1);
            end else begin
              cnt_q <= WIDTH'(cnt_q + 1'b1);
            end
          end
        end
        S_HOLD: if (bus.stop) cnt_q <= '0;
        S_DONE: cnt_q <= '0;
        default: cnt_q <= '0;
      endcase
    end
  end

  always_comb begin
    bus.busy   = 1'b0;
    bus.paused = 1'b0;
    bus.done   = 1'b0;
    unique case (state_q)
      S_ARM, S_RUN: bus.busy = 1'b1;
      S_HOLD: begin
        bus.busy   = 1'b1;
        bus.paused = 1'b1;
      end
      S_DONE:  bus.done = 1'b1;
      default: ;
    endcase
  end

  assign bus.cnt      = cnt_q;
  assign bus.rep_cnt  = rep_q;
  assign bus.tc_pulse = tc_q;

endmodule

// File: tb/tb_cnt_run_ctrl.sv
// Scoreboard bench for cnt_run_ctrl: expected per-edge status is queued when a
// run is launched and compared after every rising edge.
module tb_cnt_run_ctrl;
  localparam int WIDTH = 4;
  localparam int REP_W = 4;

  logic sys_clk = 1'b0;
  logic sys_rst_n;
  always #5 sys_clk = ~sys_clk;

  cnt_run_ctrl_if #(.WIDTH(WIDTH), .REP_W(REP_W)) bus ();

  cnt_run_ctrl #(.WIDTH(WIDTH), .REP_W(REP_W)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .bus       (bus)
  );

  typedef struct {
    logic [WIDTH-1:0] cnt;
    logic [REP_W-1:0] rep;
    bit               chk_rep;
    bit               busy;
    bit               paused;
    bit               tc;
    bit               done;
  } exp_t;

  exp_t sb[$];
  int   done_cyc[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   start_cyc;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic push(input int c, input int r, input int chk_rep,
                      input int busy, input int paused, input int tc, input int done);
    exp_t e;
    e.cnt     = WIDTH'(c);
    e.rep     = REP_W'(r);
    e.chk_rep = (chk_rep != 0);
    e.busy    = (busy != 0);
    e.paused  = (paused != 0);
    e.tc      = (tc != 0);
    e.done    = (done != 0);
    sb.push_back(e);
  endtask

  task automatic push_idle();
    push(0, 0, 0, 0, 0, 0, 0);
  endtask

  // Uninterrupted run: arm-entry edge, ARM->RUN edge, then reps periods of lim+1 edges.
  task automatic push_run(input int lim, input int reps);
    int r_eff;
    r_eff = (reps == 0) ? 1 : reps;
    push(0, 0, 0, 1, 0, 0, 0);
    push(0, 0, 1, 1, 0, 0, 0);
    for (int p = 0; p < r_eff; p++) begin
      for (int c = 1; c <= lim; c++) push(c, p, 1, 1, 0, 0, 0);
      push(0, p + 1, 1, (p + 1 == r_eff) ? 0 : 1, 0, 1, (p + 1 == r_eff) ? 1 : 0);
    end
  endtask

  task automatic tick();
    exp_t e;
    @(posedge sys_clk);
    @(negedge sys_clk);
    cyc++;
    if (bus.done) done_cyc.push_back(cyc);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("cnt", bus.cnt, e.cnt);
      if (e.chk_rep) check("rep_cnt", bus.rep_cnt, e.rep);
      check("busy", bus.busy, e.busy);
      check("paused", bus.paused, e.paused);
      check("tc_pulse", bus.tc_pulse, e.tc);
      check("done", bus.done, e.done);
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic launch(input int lim, input int reps, input int auto_en);
    bus.cfg_limit = WIDTH'(lim);
    bus.cfg_reps  = REP_W'(reps);
    bus.cfg_auto  = (auto_en != 0);
    bus.start     = 1'b1;
    done_cyc.delete();
    start_cyc = cyc + 1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_cnt"}, bus.cnt, 0);
    check({tag, "_rep"}, bus.rep_cnt, 0);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_paused"}, bus.paused, 0);
    check({tag, "_tc"}, bus.tc_pulse, 0);
    check({tag, "_done"}, bus.done, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    sys_rst_n     = 1'b0;
    bus.start     = 1'b0;
    bus.pause     = 1'b0;
    bus.stop      = 1'b0;
    bus.cfg_limit = '0;
    bus.cfg_reps  = '0;
    bus.cfg_auto  = 1'b0;
    #2;
    check_all_zero("reset");
    @(negedge sys_clk);
    sys_rst_n = 1'b1;

    // T1: limit 3, two periods, done 9 edges after the start edge
    launch(3, 2, 0);
    push_run(3, 2);
    push_idle();
    tick();
    bus.start = 1'b0;
    ticks(10);
    check("t1_done_count", done_cyc.size(), 1);
    if (done_cyc.size() == 1) check("t1_done_latency", done_cyc[0] - start_cyc, 9);

    // T2: limit 0, reps 0 behaves as one period of one cycle
    launch(0, 0, 0);
    push_run(0, 0);
    push_idle();
    tick();
    bus.start = 1'b0;
    ticks(3);
    check("t2_done_count", done_cyc.size(), 1);
    if (done_cyc.size() == 1) check("t2_done_latency", done_cyc[0] - start_cyc, 2);

    // T3: pause sampled on two edges at cnt=2 -> three cycles in HOLD/resume, done 3 edges late
    launch(5, 1, 0);
    push(0, 0, 0, 1, 0, 0, 0);
    push(0, 0, 1, 1, 0, 0, 0);
    push(1, 0, 1, 1, 0, 0, 0);
    push(2, 0, 1, 1, 0, 0, 0);
    push(2, 0, 1, 1, 1, 0, 0);
    push(2, 0, 1, 1, 1, 0, 0);
    push(2, 0, 1, 1, 0, 0, 0);
    push(3, 0, 1, 1, 0, 0, 0);
    push(4, 0, 1, 1, 0, 0, 0);
    push(5, 0, 1, 1, 0, 0, 0);
    push(0, 1, 1, 0, 0, 1, 1);
    push_idle();
    tick();
    bus.start = 1'b0;
    ticks(3);
    bus.pause = 1'b1;
    ticks(2);
    bus.pause = 1'b0;
    ticks(6);
    check("t3_done_count", done_cyc.size(), 1);
    if (done_cyc.size() == 1) check("t3_done_latency", done_cyc[0] - start_cyc, (1 + 6) + 3);

    // T4a: stop at cnt=3 -> IDLE on the next edge, no done
    launch(4, 1, 0);
    push(0, 0, 0, 1, 0, 0, 0);
    push(0, 0, 1, 1, 0, 0, 0);
    for (int c = 1; c <= 3; c++) push(c, 0, 1, 1, 0, 0, 0);
    push_idle();
    tick();
    bus.start = 1'b0;
    ticks(4);
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;

    // T4b: stop held on the wrap edge -> no tc_pulse, no done
    launch(4, 1, 0);
    push(0, 0, 0, 1, 0, 0, 0);
    push(0, 0, 1, 1, 0, 0, 0);
    for (int c = 1; c <= 4; c++) push(c, 0, 1, 1, 0, 0, 0);
    push_idle();
    push_idle();
    tick();
    bus.start = 1'b0;
    ticks(5);
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    tick();
    check("t4_done_count", done_cyc.size(), 0);

    // T5: auto re-arm every 6 cycles; config edits and held start are ignored until stop
    launch(1, 2, 1);
    push_run(1, 2);
    push_run(1, 2);
    push_run(1, 2);
    push(0, 0, 0, 1, 0, 0, 0);
    push_idle();
    tick();
    bus.cfg_limit = WIDTH'(3);
    bus.cfg_reps  = REP_W'(1);
    bus.cfg_auto  = 1'b0;
    ticks(5);
    ticks(12);
    bus.start = 1'b0;
    tick();
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    check("t5_done_count", done_cyc.size(), 3);
    if (done_cyc.size() == 3) begin
      check("t5_period_a", done_cyc[1] - done_cyc[0], 6);
      check("t5_period_b", done_cyc[2] - done_cyc[1], 6);
    end

    // T6: asynchronous reset between edges mid-RUN, then a normal run
    launch(7, 3, 0);
    push(0, 0, 0, 1, 0, 0, 0);
    push(0, 0, 1, 1, 0, 0, 0);
    for (int c = 1; c <= 3; c++) push(c, 0, 1, 1, 0, 0, 0);
    tick();
    bus.start = 1'b0;
    ticks(4);
    #2 sys_rst_n = 1'b0;
    #1 check_all_zero("t6_async_rst");
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    launch(2, 1, 0);
    push_run(2, 1);
    push_idle();
    tick();
    bus.start = 1'b0;
    ticks(5);
    check("t6_done_count", done_cyc.size(), 1);
    if (done_cyc.size() == 1) check("t6_done_latency", done_cyc[0] - start_cyc, 4);

    check("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
